// File: rtl/bpred_btb_ras_pkg.sv
// Shared definitions for the BTB/RAS branch predictor: entry type and
// 2-bit counter encodings plus small helpers used by the update path.
package bpred_btb_ras_pkg;

    // Kind of control transfer remembered by a BTB entry
    typedef enum logic [1:0] {
        BTB_COND = 2'd0,
        BTB_JMP  = 2'd1,
        BTB_CALL = 2'd2,
        BTB_RET  = 2'd3
    } btb_type_e;

    // 2-bit saturating direction counter states
    localparam logic [1:0] CTR_SNT  = 2'd0;
    localparam logic [1:0] CTR_WNT  = 2'd1;
    localparam logic [1:0] CTR_WT   = 2'd2;
    localparam logic [1:0] CTR_ST   = 2'd3;

    // A freshly allocated entry starts weakly taken
    localparam logic [1:0] CTR_INIT = CTR_WT;

    // Derive the entry type from the resolved-branch flags (call wins over ret)
    function automatic btb_type_e btb_type_from_flags(
        input logic is_call,
        input logic is_ret,
        input logic is_jmp
    );
        btb_type_e t;
        if (is_call) begin
            t = BTB_CALL;
        end else if (is_ret) begin
            t = BTB_RET;
        end else if (is_jmp) begin
            t = BTB_JMP;
        end else begin
            t = BTB_COND;
        end
        return t;
    endfunction

    // Saturating counter step: up on taken, down on not taken
    function automatic logic [1:0] ctr_update(
        input logic [1:0] ctr,
        input logic       taken
    );
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == CTR_ST) ? CTR_ST : (ctr + 2'd1);
        end else begin
            nxt = (ctr == CTR_SNT) ? CTR_SNT : (ctr - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bpred_btb_ras_chk.sv
// Simulation checks on the resolved-branch stream feeding the predictor.
module bpred_btb_ras_chk (
    input  logic clk_i,
    input  logic rst_i,
    input  logic branch_request_i,
    input  logic branch_is_taken_i,
    input  logic branch_is_not_taken_i,
    input  logic branch_is_call_i,
    input  logic branch_is_ret_i
);

    // A resolved branch is exactly one of taken / not taken, and never both call and ret
    always @(posedge clk_i) begin
        if (!rst_i && branch_request_i) begin
            assert (branch_is_taken_i ^ branch_is_not_taken_i)
                else $error("bpred: request with taken=%b not_taken=%b",
                            branch_is_taken_i, branch_is_not_taken_i);
            assert (!(branch_is_call_i && branch_is_ret_i))
                else $error("bpred: request flagged as both call and ret");
        end
    end

endmodule

// File: rtl/bpred_ras.sv
// Return-address stack. Circular storage: a push when full overwrites the
// oldest slot (the write pointer has wrapped onto it) and the count holds.
// A pop when empty does nothing.
module bpred_ras #(
    parameter int NUM_RAS_ENTRIES = 4,
    parameter int NUM_RAS_DEPTH_W = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [31:0]                push_addr_i,
    output logic [31:0]                top_o,
    output logic [NUM_RAS_DEPTH_W:0]   count_o
);

    localparam logic [NUM_RAS_DEPTH_W-1:0] PTR_ONE    = NUM_RAS_DEPTH_W'(1);
    localparam logic [NUM_RAS_DEPTH_W:0]   CNT_ONE    = (NUM_RAS_DEPTH_W + 1)'(1);
    localparam logic [NUM_RAS_DEPTH_W:0]   CNT_EMPTY  = (NUM_RAS_DEPTH_W + 1)'(0);
    localparam logic [NUM_RAS_DEPTH_W:0]   CNT_FULL   = (NUM_RAS_DEPTH_W + 1)'(NUM_RAS_ENTRIES);

    logic [31:0]                stack_r [NUM_RAS_ENTRIES];
    logic [NUM_RAS_DEPTH_W-1:0] wr_ptr_r;
    logic [NUM_RAS_DEPTH_W:0]   count_r;
    logic [NUM_RAS_DEPTH_W-1:0] top_ptr_s;

    // The top of stack sits just below the next write slot
    assign top_ptr_s = wr_ptr_r - PTR_ONE;
    assign top_o     = stack_r[top_ptr_s];
    assign count_o   = count_r;

    // Stack storage, write pointer and occupancy; push has priority over pop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_RAS_ENTRIES; i++) begin
                stack_r[i] <= 32'h0;
            end
            wr_ptr_r <= '0;
            count_r  <= CNT_EMPTY;
        end else if (push_i) begin
            stack_r[wr_ptr_r] <= push_addr_i;
            wr_ptr_r          <= wr_ptr_r + PTR_ONE;
            count_r           <= (count_r == CNT_FULL) ? CNT_FULL : (count_r + CNT_ONE);
        end else if (pop_i && (count_r != CNT_EMPTY)) begin
            wr_ptr_r <= wr_ptr_r - PTR_ONE;
            count_r  <= count_r - CNT_ONE;
        end
    end

endmodule

// File: rtl/bpred_btb_ras.sv
// Branch predictor: fully-associative BTB with per-entry 2-bit counters and a
// non-speculative return-address stack, trained by the resolved-branch stream.
// The next-PC prediction is combinational from the current fetch PC and sees
// state from before any update happening in the same cycle.
module bpred_btb_ras
    import bpred_btb_ras_pkg::*;
#(
    parameter int NUM_BTB_ENTRIES = 8,
    parameter int NUM_BTB_DEPTH_W = 3,
    parameter int NUM_RAS_ENTRIES = 4,
    parameter int NUM_RAS_DEPTH_W = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     branch_request_i,
    input  logic                     branch_is_taken_i,
    input  logic                     branch_is_not_taken_i,
    input  logic [31:0]              branch_source_i,
    input  logic [31:0]              branch_pc_i,
    input  logic                     branch_is_call_i,
    input  logic                     branch_is_ret_i,
    input  logic                     branch_is_jmp_i,
    input  logic [31:0]              pc_f_i,
    output logic [31:0]              next_pc_f_o,
    output logic                     next_taken_f_o,
    output logic [NUM_RAS_DEPTH_W:0] ras_count_o
);

    localparam logic [NUM_BTB_DEPTH_W-1:0] VICTIM_ONE = NUM_BTB_DEPTH_W'(1);
    localparam logic [NUM_RAS_DEPTH_W:0]   RAS_EMPTY  = (NUM_RAS_DEPTH_W + 1)'(0);

    // BTB state
    logic [NUM_BTB_ENTRIES-1:0] valid_r;
    logic [29:0]                tag_r   [NUM_BTB_ENTRIES];
    logic [31:0]                tgt_r   [NUM_BTB_ENTRIES];
    logic [1:0]                 ctr_r   [NUM_BTB_ENTRIES];
    btb_type_e                  type_r  [NUM_BTB_ENTRIES];
    logic [NUM_BTB_DEPTH_W-1:0] victim_r;

    // Lookup / update match vectors
    logic [NUM_BTB_ENTRIES-1:0] look_match_s;
    logic [NUM_BTB_ENTRIES-1:0] upd_match_s;
    logic [NUM_BTB_DEPTH_W-1:0] look_idx_s;
    logic [NUM_BTB_DEPTH_W-1:0] upd_idx_s;
    logic                       look_hit_s;
    logic                       upd_hit_s;
    btb_type_e                  upd_type_s;

    // Prediction and RAS wiring
    logic [31:0]                pc_plus4_s;
    logic [31:0]                pred_pc_s;
    logic                       pred_taken_s;
    logic [31:0]                ras_top_s;
    logic [NUM_RAS_DEPTH_W:0]   ras_count_s;
    logic                       ras_push_s;
    logic                       ras_pop_s;

    assign pc_plus4_s = pc_f_i + 32'd4;
    assign upd_type_s = btb_type_from_flags(branch_is_call_i, branch_is_ret_i, branch_is_jmp_i);

    // CAM match for the fetch PC and the resolved source; tags are unique so
    // OR-ing the indices of matching entries yields the single hit index
    always_comb begin
        look_match_s = '0;
        upd_match_s  = '0;
        look_idx_s   = '0;
        upd_idx_s    = '0;
        for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
            look_match_s[i] = valid_r[i] && (tag_r[i] == pc_f_i[31:2]);
            upd_match_s[i]  = valid_r[i] && (tag_r[i] == branch_source_i[31:2]);
            look_idx_s     |= look_match_s[i] ? NUM_BTB_DEPTH_W'(i) : '0;
            upd_idx_s      |= upd_match_s[i]  ? NUM_BTB_DEPTH_W'(i) : '0;
        end
    end

    assign look_hit_s = |look_match_s;
    assign upd_hit_s  = |upd_match_s;

    // Next-PC selection from the hit entry's type, counter and the RAS
    always_comb begin
        pred_pc_s    = pc_plus4_s;
        pred_taken_s = 1'b0;
        if (look_hit_s) begin
            case (type_r[look_idx_s])
                BTB_RET: begin
                    pred_taken_s = 1'b1;
                    if (ras_count_s != RAS_EMPTY) begin
                        pred_pc_s = ras_top_s;
                    end else begin
                        pred_pc_s = tgt_r[look_idx_s];
                    end
                end
                BTB_JMP, BTB_CALL: begin
                    pred_taken_s = 1'b1;
                    pred_pc_s    = tgt_r[look_idx_s];
                end
                BTB_COND: begin
                    if (ctr_r[look_idx_s][1]) begin
                        pred_taken_s = 1'b1;
                        pred_pc_s    = tgt_r[look_idx_s];
                    end else begin
                        pred_taken_s = 1'b0;
                        pred_pc_s    = pc_plus4_s;
                    end
                end
                default: begin
                    pred_taken_s = 1'b0;
                    pred_pc_s    = pc_plus4_s;
                end
            endcase
        end else begin
            pred_taken_s = 1'b0;
            pred_pc_s    = pc_plus4_s;
        end
    end

    assign next_pc_f_o    = pred_pc_s;
    assign next_taken_f_o = pred_taken_s;
    assign ras_count_o    = ras_count_s;

    // BTB training: refresh a hit entry, or allocate round-robin on a taken miss
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
                tag_r[i]   <= 30'h0;
                tgt_r[i]   <= 32'h0;
                ctr_r[i]   <= CTR_SNT;
                type_r[i]  <= BTB_COND;
            end
            victim_r <= '0;
        end else if (branch_request_i) begin
            if (upd_hit_s) begin
                ctr_r[upd_idx_s]  <= ctr_update(ctr_r[upd_idx_s], branch_is_taken_i);
                type_r[upd_idx_s] <= upd_type_s;
                if (branch_is_taken_i) begin
                    tgt_r[upd_idx_s] <= branch_pc_i;
                end
            end else if (branch_is_taken_i) begin
                valid_r[victim_r] <= 1'b1;
                tag_r[victim_r]   <= branch_source_i[31:2];
                tgt_r[victim_r]   <= branch_pc_i;
                ctr_r[victim_r]   <= CTR_INIT;
                type_r[victim_r]  <= upd_type_s;
                victim_r          <= victim_r + VICTIM_ONE;
            end
        end
    end

    // RAS follows resolved calls and returns only
    assign ras_push_s = branch_request_i && branch_is_call_i;
    assign ras_pop_s  = branch_request_i && branch_is_ret_i && !branch_is_call_i;

    bpred_ras #(
        .NUM_RAS_ENTRIES (NUM_RAS_ENTRIES),
        .NUM_RAS_DEPTH_W (NUM_RAS_DEPTH_W)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (ras_push_s),
        .pop_i       (ras_pop_s),
        .push_addr_i (branch_source_i + 32'd4),
        .top_o       (ras_top_s),
        .count_o     (ras_count_s)
    );

    bpred_btb_ras_chk u_chk (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .branch_request_i      (branch_request_i),
        .branch_is_taken_i     (branch_is_taken_i),
        .branch_is_not_taken_i (branch_is_not_taken_i),
        .branch_is_call_i      (branch_is_call_i),
        .branch_is_ret_i       (branch_is_ret_i)
    );

endmodule

// File: tb/tb_bpred_btb_ras.sv
// Directed bench for bpred_btb_ras: expected predictions are queued when a
// fetch PC is applied and compared once the combinational output settles.
module tb_bpred_btb_ras;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        branch_request_i;
    logic        branch_is_taken_i;
    logic        branch_is_not_taken_i;
    logic [31:0] branch_source_i;
    logic [31:0] branch_pc_i;
    logic        branch_is_call_i;
    logic        branch_is_ret_i;
    logic        branch_is_jmp_i;
    logic [31:0] pc_f_i;
    logic [31:0] next_pc_f_o;
    logic        next_taken_f_o;
    logic [2:0]  ras_count_o;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        tk;
        logic [2:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk_i = ~clk_i;

    bpred_btb_ras dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .branch_request_i      (branch_request_i),
        .branch_is_taken_i     (branch_is_taken_i),
        .branch_is_not_taken_i (branch_is_not_taken_i),
        .branch_source_i       (branch_source_i),
        .branch_pc_i           (branch_pc_i),
        .branch_is_call_i      (branch_is_call_i),
        .branch_is_ret_i       (branch_is_ret_i),
        .branch_is_jmp_i       (branch_is_jmp_i),
        .pc_f_i                (pc_f_i),
        .next_pc_f_o           (next_pc_f_o),
        .next_taken_f_o        (next_taken_f_o),
        .ras_count_o           (ras_count_o)
    );

    task automatic clear_branch();
        branch_request_i      = 1'b0;
        branch_is_taken_i     = 1'b0;
        branch_is_not_taken_i = 1'b0;
        branch_is_call_i      = 1'b0;
        branch_is_ret_i       = 1'b0;
        branch_is_jmp_i       = 1'b0;
        branch_source_i       = 32'h0;
        branch_pc_i           = 32'h0;
    endtask

    task automatic set_branch(input logic tk, input logic [31:0] src, input logic [31:0] tgt,
                              input logic call, input logic ret, input logic jmp);
        branch_request_i      = 1'b1;
        branch_is_taken_i     = tk;
        branch_is_not_taken_i = ~tk;
        branch_source_i       = src;
        branch_pc_i           = tgt;
        branch_is_call_i      = call;
        branch_is_ret_i       = ret;
        branch_is_jmp_i       = jmp;
    endtask

    // Resolve one branch: held across one rising edge
    task automatic branch(input logic tk, input logic [31:0] src, input logic [31:0] tgt,
                          input logic call, input logic ret, input logic jmp);
        set_branch(tk, src, tgt, call, ret, jmp);
        @(negedge clk_i);
        clear_branch();
    endtask

    task automatic compare();
        exp_t e;
        n_assert++;
        assert (sb_q.size() != 0)
            else begin n_fail++; $error("FAIL sb_underflow got 0 entries expected >0"); end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_assert++;
            assert (next_pc_f_o === e.pc)
                else begin n_fail++; $error("FAIL %s next_pc got %h expected %h", e.tag, next_pc_f_o, e.pc); end
            n_assert++;
            assert (next_taken_f_o === e.tk)
                else begin n_fail++; $error("FAIL %s taken got %b expected %b", e.tag, next_taken_f_o, e.tk); end
            n_assert++;
            assert (ras_count_o === e.cnt)
                else begin n_fail++; $error("FAIL %s ras_count got %0d expected %0d", e.tag, ras_count_o, e.cnt); end
        end
    endtask

    // Apply a fetch PC, queue the expectation, sample mid-phase, realign to negedge
    task automatic check(input string tag, input logic [31:0] pc, input logic [31:0] exp_pc,
                         input logic exp_tk, input logic [2:0] exp_cnt);
        exp_t e;
        e.tag = tag; e.pc = exp_pc; e.tk = exp_tk; e.cnt = exp_cnt;
        pc_f_i = pc;
        sb_q.push_back(e);
        #2;
        compare();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i  = 1'b1;
        pc_f_i = 32'h0;
        clear_branch();
        @(negedge clk_i);
        do_reset();

        // 1: reset state
        check("reset", 32'h100, 32'h104, 1'b0, 3'd0);

        // 2: conditional training and counter saturation
        branch(1'b1, 32'h200, 32'h80, 1'b0, 1'b0, 1'b0);
        check("cond_alloc", 32'h200, 32'h80, 1'b1, 3'd0);
        branch(1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0);
        check("cond_wnt", 32'h200, 32'h204, 1'b0, 3'd0);
        branch(1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0);
        branch(1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0);
        check("ctr_sat_lo", 32'h200, 32'h204, 1'b0, 3'd0);
        branch(1'b1, 32'h200, 32'h80, 1'b0, 1'b0, 1'b0);
        branch(1'b1, 32'h200, 32'h80, 1'b0, 1'b0, 1'b0);
        check("ctr_up", 32'h200, 32'h80, 1'b1, 3'd0);
        branch(1'b1, 32'h200, 32'h80, 1'b0, 1'b0, 1'b0);
        branch(1'b1, 32'h200, 32'h80, 1'b0, 1'b0, 1'b0);
        check("ctr_sat_hi", 32'h200, 32'h80, 1'b1, 3'd0);
        branch(1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0);
        check("ctr_st_to_wt", 32'h200, 32'h80, 1'b1, 3'd0);
        branch(1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0);
        check("ctr_wt_to_wnt", 32'h200, 32'h204, 1'b0, 3'd0);
        branch(1'b1, 32'h200, 32'h90, 1'b0, 1'b0, 1'b0);
        check("tgt_update", 32'h200, 32'h90, 1'b1, 3'd0);

        // Same-cycle update is invisible to the lookup until the next cycle
        set_branch(1'b1, 32'h600, 32'h640, 1'b0, 1'b0, 1'b0);
        check("same_cycle_pre", 32'h600, 32'h604, 1'b0, 3'd0);
        clear_branch();
        check("same_cycle_post", 32'h600, 32'h640, 1'b1, 3'd0);

        // PC arithmetic wraps
        check("pc_wrap", 32'hFFFF_FFFC, 32'h0, 1'b0, 3'd0);

        // Jumps redirect regardless of counter
        branch(1'b1, 32'h700, 32'h720, 1'b0, 1'b0, 1'b1);
        branch(1'b0, 32'h700, 32'h0, 1'b0, 1'b0, 1'b1);
        check("jmp_ignores_ctr", 32'h700, 32'h720, 1'b1, 3'd0);

        // 3: call/ret via RAS, then fallback to BTB target
        branch(1'b1, 32'h1000, 32'h5000, 1'b1, 1'b0, 1'b0);
        branch(1'b1, 32'h2000, 32'h6000, 1'b1, 1'b0, 1'b0);
        check("call_hit", 32'h1000, 32'h5000, 1'b1, 3'd2);
        branch(1'b1, 32'h3000, 32'h2004, 1'b0, 1'b1, 1'b0);
        check("ret_from_ras", 32'h3000, 32'h1004, 1'b1, 3'd1);
        branch(1'b1, 32'h3000, 32'h1004, 1'b0, 1'b1, 1'b0);
        check("ret_btb_fallback", 32'h3000, 32'h1004, 1'b1, 3'd0);

        // 4: overflow keeps newest four, then pop order and empty pop
        for (int k = 1; k <= 5; k++) begin
            branch(1'b1, 32'(k * 16), 32'h9000, 1'b1, 1'b0, 1'b0);
        end
        check("ras_full", 32'h3000, 32'h54, 1'b1, 3'd4);
        branch(1'b1, 32'h3000, 32'h1004, 1'b0, 1'b1, 1'b0);
        check("ras_pop1", 32'h3000, 32'h44, 1'b1, 3'd3);
        branch(1'b1, 32'h3000, 32'h1004, 1'b0, 1'b1, 1'b0);
        check("ras_pop2", 32'h3000, 32'h34, 1'b1, 3'd2);
        branch(1'b1, 32'h3000, 32'h1004, 1'b0, 1'b1, 1'b0);
        check("ras_pop3", 32'h3000, 32'h24, 1'b1, 3'd1);
        branch(1'b1, 32'h3000, 32'h1004, 1'b0, 1'b1, 1'b0);
        check("ras_pop4", 32'h3000, 32'h1004, 1'b1, 3'd0);
        branch(1'b1, 32'h3000, 32'h1004, 1'b0, 1'b1, 1'b0);
        check("ras_pop_empty", 32'h3000, 32'h1004, 1'b1, 3'd0);

        // 5: replacement order
        do_reset();
        for (int k = 0; k < 9; k++) begin
            branch(1'b1, 32'h400 + 32'(k * 16), 32'h8000 + 32'(k * 16), 1'b0, 1'b0, 1'b0);
        end
        check("evict_first", 32'h400, 32'h404, 1'b0, 3'd0);
        for (int k = 1; k < 9; k++) begin
            check("keep_rest", 32'h400 + 32'(k * 16), 32'h8000 + 32'(k * 16), 1'b1, 3'd0);
        end
        branch(1'b1, 32'h900, 32'h8900, 1'b0, 1'b0, 1'b0);
        check("victim_wrap_evict", 32'h410, 32'h414, 1'b0, 3'd0);
        check("victim_wrap_keep", 32'h420, 32'h8020, 1'b1, 3'd0);
        check("victim_wrap_new", 32'h900, 32'h8900, 1'b1, 3'd0);

        // 6: reset wins over a same-cycle request
        branch(1'b1, 32'h40, 32'hA000, 1'b1, 1'b0, 1'b0);
        check("pre_reset_call", 32'h40, 32'hA000, 1'b1, 3'd1);
        rst_i = 1'b1;
        set_branch(1'b1, 32'h700, 32'h710, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        clear_branch();
        check("rst_drops_req", 32'h700, 32'h704, 1'b0, 3'd0);
        check("rst_clears_btb", 32'h40, 32'h44, 1'b0, 3'd0);

        n_assert++;
        assert (sb_q.size() == 0)
            else begin n_fail++; $error("FAIL sb_drain got %0d entries expected 0", sb_q.size()); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
